// File: rtl/ritc_phase_scan_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ritc_phase_scan_pkg                                                  |
// | Shared state encoding and select constants for the RITC phase scan. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package ritc_phase_scan_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_SETTLE    = 4'd1,
        ST_SAMPLE    = 4'd2,
        ST_REPORT    = 4'd3,
        ST_STEP      = 4'd4,
        ST_WAIT_DONE = 4'd5,
        ST_RET_STEP  = 4'd6,
        ST_RET_WAIT  = 4'd7,
        ST_FINISH    = 4'd8
    } state_t;

    localparam logic [5:0] SEL_CLK_BASE  = 6'd0;
    localparam logic [5:0] SEL_DATA_BASE = 6'd3;
    localparam logic [5:0] SEL_VCDL      = 6'd39;
    localparam logic [5:0] SEL_MAX       = 6'd39;

    localparam int PS_TIMEOUT = 255;

endpackage
`default_nettype wire

// File: rtl/ritc_phase_scan_mux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ritc_phase_scan_mux                                                  |
// | Registered 40:1 bit select over the synchronized RITC samples.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ritc_phase_scan_mux (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  i_sel,
    input  logic [2:0]  i_clk_q,
    input  logic [11:0] i_ch0_q,
    input  logic [11:0] i_ch1_q,
    input  logic [11:0] i_ch2_q,
    input  logic        i_vcdl_q,
    output logic        o_bit
);
    import ritc_phase_scan_pkg::*;

    // Padded to 64 so any 6-bit select indexes a defined bit.
    logic [63:0] w_vec;

    always_comb begin
        w_vec                       = '0;
        w_vec[SEL_CLK_BASE +: 3]    = i_clk_q;
        w_vec[SEL_DATA_BASE +: 36]  = {i_ch2_q, i_ch1_q, i_ch0_q};
        w_vec[SEL_VCDL]             = i_vcdl_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_bit <= 1'b0;
        end else begin
            o_bit <= (i_sel <= SEL_MAX) ? w_vec[i_sel] : 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ritc_phase_scan_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ritc_phase_scan_controller                                           |
// | Steps the MMCM fine phase, integrates one selected input bit per     |
// | step and records the first rising/falling transitions.              |
// | Option: RITC_PHASE_SCAN_RETURN_EN shifts the phase back at the end.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ritc_phase_scan_controller #(
    parameter int NUM_STEPS    = 448,
    parameter int SETTLE       = 8,
    parameter int LOG2_SAMPLES = 4,
    parameter int STEP_W       = 12
) (
    input  logic                    user_clk_i,
    input  logic                    user_rst_n_i,
    input  logic                    start_i,
    input  logic [5:0]              sel_i,
    input  logic [2:0]              clk_q_i,
    input  logic [11:0]             ch0_q_i,
    input  logic [11:0]             ch1_q_i,
    input  logic [11:0]             ch2_q_i,
    input  logic                    vcdl_q_i,
    output logic                    ps_en_o,
    output logic                    ps_incdec_o,
    input  logic                    ps_done_i,
    output logic                    scan_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic                    step_valid_o,
    output logic [STEP_W-1:0]       step_idx_o,
    output logic [LOG2_SAMPLES:0]   step_count_o,
    output logic                    rise_found_o,
    output logic                    fall_found_o,
    output logic [STEP_W-1:0]       rise_step_o,
    output logic [STEP_W-1:0]       fall_step_o
);
    import ritc_phase_scan_pkg::*;

    localparam int TMR_W = 16;
    localparam logic [LOG2_SAMPLES:0] c_half = (LOG2_SAMPLES+1)'(2 ** (LOG2_SAMPLES - 1));

    state_t                 r_state;
    logic [5:0]             r_sel;
    logic [STEP_W-1:0]      r_step;
    logic [TMR_W-1:0]       r_timer;
    logic [LOG2_SAMPLES-1:0] r_samp;
    logic [LOG2_SAMPLES:0]  r_count;
    logic                   r_prev_lvl;
`ifdef RITC_PHASE_SCAN_RETURN_EN
    logic [STEP_W-1:0]      r_ret;
`endif

    logic w_bit;
    logic w_level;

    ritc_phase_scan_mux u_mux (
        .clk      (user_clk_i),
        .rst_n    (user_rst_n_i),
        .i_sel    (r_sel),
        .i_clk_q  (clk_q_i),
        .i_ch0_q  (ch0_q_i),
        .i_ch1_q  (ch1_q_i),
        .i_ch2_q  (ch2_q_i),
        .i_vcdl_q (vcdl_q_i),
        .o_bit    (w_bit)
    );

    // Exactly half is treated as low so a jittering edge does not count as high.
    assign w_level = (r_count > c_half);

    always_ff @(posedge user_clk_i or negedge user_rst_n_i) begin
        if (!user_rst_n_i) begin
            r_state      <= ST_IDLE;
            r_sel        <= '0;
            r_step       <= '0;
            r_timer      <= '0;
            r_samp       <= '0;
            r_count      <= '0;
            r_prev_lvl   <= 1'b0;
`ifdef RITC_PHASE_SCAN_RETURN_EN
            r_ret        <= '0;
`endif
            ps_en_o      <= 1'b0;
            ps_incdec_o  <= 1'b0;
            scan_o       <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            step_valid_o <= 1'b0;
            step_idx_o   <= '0;
            step_count_o <= '0;
            rise_found_o <= 1'b0;
            fall_found_o <= 1'b0;
            rise_step_o  <= '0;
            fall_step_o  <= '0;
        end else begin
            scan_o       <= 1'b0;
            step_valid_o <= 1'b0;
            done_o       <= 1'b0;
            ps_en_o      <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (start_i && !busy_o) begin
                        r_sel        <= sel_i;
                        r_step       <= '0;
                        r_timer      <= '0;
                        busy_o       <= 1'b1;
                        err_o        <= 1'b0;
                        rise_found_o <= 1'b0;
                        fall_found_o <= 1'b0;
                        rise_step_o  <= '0;
                        fall_step_o  <= '0;
                        if (sel_i > SEL_MAX) begin
                            err_o   <= 1'b1;
                            r_state <= ST_FINISH;
                        end else begin
                            r_state <= ST_SETTLE;
                        end
                    end
                end

                ST_SETTLE: begin
                    if (r_timer == TMR_W'(SETTLE - 1)) begin
                        r_timer <= '0;
                        r_samp  <= '0;
                        r_count <= '0;
                        scan_o  <= 1'b1;
                        r_state <= ST_SAMPLE;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end

                ST_SAMPLE: begin
                    r_count <= r_count + (LOG2_SAMPLES+1)'(w_bit);
                    r_samp  <= r_samp + LOG2_SAMPLES'(1);
                    if (&r_samp) begin
                        r_state <= ST_REPORT;
                    end
                end

                ST_REPORT: begin
                    step_valid_o <= 1'b1;
                    step_idx_o   <= r_step;
                    step_count_o <= r_count;
                    r_prev_lvl   <= w_level;
                    if (r_step != '0) begin
                        if (!r_prev_lvl && w_level && !rise_found_o) begin
                            rise_found_o <= 1'b1;
                            rise_step_o  <= r_step;
                        end
                        if (r_prev_lvl && !w_level && !fall_found_o) begin
                            fall_found_o <= 1'b1;
                            fall_step_o  <= r_step;
                        end
                    end
                    if (r_step == STEP_W'(NUM_STEPS - 1)) begin
`ifdef RITC_PHASE_SCAN_RETURN_EN
                        r_ret       <= '0;
                        ps_en_o     <= 1'b1;
                        ps_incdec_o <= 1'b0;
                        r_state     <= ST_RET_STEP;
`else
                        r_state     <= ST_FINISH;
`endif
                    end else begin
                        r_step      <= r_step + STEP_W'(1);
                        ps_en_o     <= 1'b1;
                        ps_incdec_o <= 1'b1;
                        r_state     <= ST_STEP;
                    end
                end

                // PSEN is already high for this cycle; just arm the timeout.
                ST_STEP: begin
                    r_timer <= '0;
                    r_state <= ST_WAIT_DONE;
                end

                ST_WAIT_DONE: begin
                    if (ps_done_i) begin
                        r_timer <= '0;
                        r_state <= ST_SETTLE;
                    end else if (r_timer == TMR_W'(PS_TIMEOUT - 1)) begin
                        err_o   <= 1'b1;
                        r_state <= ST_FINISH;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end

`ifdef RITC_PHASE_SCAN_RETURN_EN
                ST_RET_STEP: begin
                    r_timer <= '0;
                    r_state <= ST_RET_WAIT;
                end

                ST_RET_WAIT: begin
                    if (ps_done_i) begin
                        if (r_ret == STEP_W'(NUM_STEPS - 2)) begin
                            r_state <= ST_FINISH;
                        end else begin
                            r_ret       <= r_ret + STEP_W'(1);
                            ps_en_o     <= 1'b1;
                            ps_incdec_o <= 1'b0;
                            r_state     <= ST_RET_STEP;
                        end
                    end else if (r_timer == TMR_W'(PS_TIMEOUT - 1)) begin
                        err_o   <= 1'b1;
                        r_state <= ST_FINISH;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
`endif

                ST_FINISH: begin
                    done_o  <= 1'b1;
                    busy_o  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ritc_phase_scan_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ritc_phase_scan_controller                                        |
// | Scoreboard bench with an MMCM phase-shift and input-pattern model.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_ritc_phase_scan_controller;

    localparam int N  = 8;
    localparam int L  = 4;
    localparam int ST = 8;
    localparam int W  = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [5:0]    sel = '0;
    logic [2:0]    clk_q;
    logic [11:0]   ch0_q, ch1_q, ch2_q;
    logic          vcdl_q;
    logic          ps_en, ps_incdec, ps_done, scan, busy, done, err, step_valid;
    logic [W-1:0]  step_idx, rise_step, fall_step;
    logic [L:0]    step_count;
    logic          rise_found, fall_found;

    ritc_phase_scan_controller #(
        .NUM_STEPS(N), .SETTLE(ST), .LOG2_SAMPLES(L), .STEP_W(W)
    ) dut (
        .user_clk_i   (clk),
        .user_rst_n_i (rst_n),
        .start_i      (start),
        .sel_i        (sel),
        .clk_q_i      (clk_q),
        .ch0_q_i      (ch0_q),
        .ch1_q_i      (ch1_q),
        .ch2_q_i      (ch2_q),
        .vcdl_q_i     (vcdl_q),
        .ps_en_o      (ps_en),
        .ps_incdec_o  (ps_incdec),
        .ps_done_i    (ps_done),
        .scan_o       (scan),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err),
        .step_valid_o (step_valid),
        .step_idx_o   (step_idx),
        .step_count_o (step_count),
        .rise_found_o (rise_found),
        .fall_found_o (fall_found),
        .rise_step_o  (rise_step),
        .fall_step_o  (fall_step)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // MMCM + input model: phase moves when PSDONE is returned.
    int   phase = 0;
    int   base = 0;
    int   dly = 0;
    int   cyc = 0;
    int   n_inc = 0, n_dec = 0, n_dbl = 0, n_stab = 0;
    logic tog = 1'b0;
    logic prev_en = 1'b0;
    logic pend_dir = 1'b0;
    bit   withhold = 1'b0;
    int   kind [N];   // 0 = low, 1 = high, 2 = toggles every cycle
    logic src;

    initial ps_done = 1'b0;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        tog     <= ~tog;
        ps_done <= 1'b0;
        prev_en <= ps_en;
        if (prev_en && ps_en) n_dbl <= n_dbl + 1;
        if (ps_en) begin
            dly      <= 3;
            pend_dir <= ps_incdec;
            if (ps_incdec) n_inc <= n_inc + 1;
            else           n_dec <= n_dec + 1;
        end else if (dly > 0) begin
            if (ps_incdec !== pend_dir) n_stab <= n_stab + 1;
            dly <= dly - 1;
            if (dly == 1 && !withhold) begin
                ps_done <= 1'b1;
                phase   <= pend_dir ? phase + 1 : phase - 1;
            end
        end
    end

    always_comb begin
        int i;
        i   = phase - base;
        src = 1'b0;
        if (i >= 0 && i < N) src = (kind[i] == 2) ? tog : kind[i][0];
    end

    assign clk_q  = {~src, ~src, src};
    assign ch0_q  = {12{~src}};
    assign ch1_q  = {{6{~src}}, src, {5{~src}}};
    assign ch2_q  = {12{~src}};
    assign vcdl_q = src;

    typedef struct { int idx; int cnt; } exp_t;
    exp_t sbq [$];
    bit   exp_rf, exp_ff;
    int   exp_rs, exp_fs;

    always @(negedge clk) begin
        if (step_valid) begin
            if (sbq.size() == 0) begin
                check("sb_unexpected_strobe", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("sb_step_idx", 64'(step_idx), 64'(e.idx));
                check("sb_step_count", 64'(step_count), 64'(e.cnt));
            end
        end
    end

    task automatic push_model(input int npush);
        bit prev, lvl;
        int cnt;
        exp_rf = 0; exp_ff = 0; exp_rs = 0; exp_fs = 0; prev = 0;
        for (int s = 0; s < N; s++) begin
            cnt = (kind[s] == 0) ? 0 : (kind[s] == 1) ? 16 : 8;
            lvl = (cnt > 8);
            if (s < npush) sbq.push_back('{s, cnt});
            if (s > 0) begin
                if (!prev && lvl && !exp_rf) begin exp_rf = 1; exp_rs = s; end
                if (prev && !lvl && !exp_ff) begin exp_ff = 1; exp_fs = s; end
            end
            prev = lvl;
        end
    endtask

    task automatic set_kinds(input int k0, k1, k2, k3, k4, k5, k6, k7);
        kind[0] = k0; kind[1] = k1; kind[2] = k2; kind[3] = k3;
        kind[4] = k4; kind[5] = k5; kind[6] = k6; kind[7] = k7;
    endtask

    task automatic start_pulse(input logic [5:0] s);
        @(negedge clk);
        sel   = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (done) begin seen = 1; break; end
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
    endtask

    task automatic run_scan(input string tag, input logic [5:0] s, input bit poke);
        int inc0, dec0;
        inc0 = n_inc; dec0 = n_dec; base = phase;
        push_model(N);
        start_pulse(s);
        check({tag, "_busy_after_start"}, 64'(busy), 64'd1);
        if (poke) begin
            repeat (30) @(negedge clk);
            start_pulse(6'd45);
        end
        wait_done(tag);
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
        check({tag, "_rise_found"}, 64'(rise_found), 64'(exp_rf));
        check({tag, "_rise_step"}, 64'(rise_step), 64'(exp_rs));
        check({tag, "_fall_found"}, 64'(fall_found), 64'(exp_ff));
        check({tag, "_fall_step"}, 64'(fall_step), 64'(exp_fs));
        check({tag, "_inc_pulses"}, 64'(n_inc - inc0), 64'(N - 1));
`ifdef RITC_PHASE_SCAN_RETURN_EN
        check({tag, "_dec_pulses"}, 64'(n_dec - dec0), 64'(N - 1));
        check({tag, "_phase_end"}, 64'(phase - base), 64'd0);
`else
        check({tag, "_dec_pulses"}, 64'(n_dec - dec0), 64'd0);
        check({tag, "_phase_end"}, 64'(phase - base), 64'(N - 1));
`endif
        check({tag, "_sb_left"}, 64'(sbq.size()), 64'd0);
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({ps_en, ps_incdec, scan, busy, done, err, step_valid, step_idx,
                    step_count, rise_found, fall_found, rise_step, fall_step});
    endfunction

    initial begin
        int t_en, pulses0;
        bit seen;
        set_kinds(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outs(), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        set_kinds(0, 0, 0, 1, 1, 1, 1, 1);
        run_scan("clk0", 6'd0, 1'b0);

        set_kinds(1, 1, 0, 0, 1, 1, 2, 1);
        run_scan("vcdl", 6'd39, 1'b1);

        set_kinds(0, 1, 1, 0, 0, 1, 0, 1);
        run_scan("ch1b5", 6'd20, 1'b0);

        // Illegal select: immediate error, no shifts, no strobes.
        pulses0 = n_inc + n_dec;
        start_pulse(6'd45);
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) begin seen = 1; break; end
        end
        check("illegal_done", 64'(seen), 64'd1);
        check("illegal_err", 64'(err), 64'd1);
        repeat (4) @(negedge clk);
        check("illegal_no_psen", 64'(n_inc + n_dec - pulses0), 64'd0);

        // PSDONE withheld: 255 WAIT_DONE cycles, one FINISH cycle, then done.
        set_kinds(0, 0, 0, 0, 0, 0, 0, 0);
        withhold = 1'b1;
        base = phase;
        push_model(1);
        start_pulse(6'd0);
        t_en = -1;
        for (int i = 0; i < 200; i++) begin
            if (ps_en) begin t_en = cyc; break; end
            @(negedge clk);
        end
        check("timeout_psen_seen", 64'(t_en >= 0), 64'd1);
        wait_done("timeout");
        check("timeout_latency", 64'(cyc - t_en), 64'd257);
        check("timeout_err", 64'(err), 64'd1);
        check("timeout_sb_left", 64'(sbq.size()), 64'd0);
        withhold = 1'b0;
        repeat (6) @(negedge clk);

        // Reset in the middle of SAMPLE.
        set_kinds(1, 1, 1, 0, 0, 0, 0, 0);
        start_pulse(6'd0);
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (scan) begin seen = 1; break; end
        end
        check("midreset_scan_seen", 64'(seen), 64'd1);
        repeat (5) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check("midreset_outputs", all_outs(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        run_scan("after_reset", 6'd0, 1'b0);

        check("psen_never_double", 64'(n_dbl), 64'd0);
        check("incdec_stable", 64'(n_stab), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired got=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/ritc_phase_scan_controller.md
# ritc_phase_scan_controller

Controller for the RITC input phase scan. Runs entirely in `user_clk_i`, which also drives the MMCM `PSCLK`. It steps the MMCM fine phase shift that generates `CLK_PS`, waits for the shifted sample registers and their 2-flop synchronizers to settle, and integrates one selected synchronized input bit per phase step. For each step it streams a ones-count, and it reports the first rising and falling transitions so software can centre the capture clock.

## Interface
Parameters:
- `NUM_STEPS`, 448: number of phase positions sampled (step 0 = starting phase); legal range 2–4095.
- `SETTLE`, 8: idle cycles after `ps_done_i` before sampling; minimum 4.
- `LOG2_SAMPLES`, 4: each step takes 2^`LOG2_SAMPLES` samples, one per cycle.
- `STEP_W`, 12: width of step indices.

Ports:
- `user_clk_i`  in  1  sole clock; also MMCM `PSCLK`.
- `user_rst_n_i`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  one-cycle start pulse; ignored while `busy_o`=1.
- `sel_i`  in  6  input select, latched at start: 0–2 `clk_q_i[n]`; 3–38 data bit `ch(k)_q_i[b]` with index = 3+12k+b; 39 `vcdl_q_i`; 40–63 illegal.
- `clk_q_i`  in  3  synchronized RITC clock samples.
- `ch0_q_i`, `ch1_q_i`, `ch2_q_i`  in  12 each  synchronized data samples.
- `vcdl_q_i`  in  1  synchronized VCDL sample.
- `ps_en_o`  out  1  MMCM PSEN.
- `ps_incdec_o`  out  1  MMCM PSINCDEC; 1 = increment.
- `ps_done_i`  in  1  MMCM PSDONE.
- `scan_o`  out  1  one-cycle marker at the start of each sample window.
- `busy_o`  out  1  scan in progress.
- `done_o`  out  1  one-cycle completion pulse.
- `err_o`  out  1  sticky error; cleared by the next accepted `start_i`.
- `step_valid_o`  out  1  one-cycle per-step result strobe.
- `step_idx_o`  out  `STEP_W`  step index of the current result.
- `step_count_o`  out  `LOG2_SAMPLES`+1  ones count for the step, 0 to 2^`LOG2_SAMPLES`.
- `rise_found_o`, `fall_found_o`  out  1 each  edge found in this scan.
- `rise_step_o`, `fall_step_o`  out  `STEP_W` each  step index of the first edge of each kind.

## Operation
States: IDLE, SETTLE, SAMPLE, REPORT, STEP, WAIT_DONE, then (with the macro) RET_STEP and RET_WAIT, then FINISH.

- **IDLE.** On `start_i`:
  - latch `sel_i`; clear step index, edge flags and `err_o`; set `busy_o`.
  - If `sel_i` > 39: set `err_o`, go to FINISH, issue no shifts.
  - Otherwise go to SETTLE (no shift before step 0).
- **SETTLE.** Count `SETTLE` cycles, then go to SAMPLE.
- **SAMPLE.** Pulse `scan_o` on the first cycle. Add the selected bit to the counter for exactly 2^`LOG2_SAMPLES` cycles.
- **REPORT.** Pulse `step_valid_o`, driving `step_idx_o` and `step_count_o`.
  - Level = 1 when count > 2^(`LOG2_SAMPLES`−1); a count of exactly half is 0.
  - For step > 0: a 0→1 transition against the previous level sets `rise_found_o`/`rise_step_o`, a 1→0 sets `fall_found_o`/`fall_step_o`. Only the first occurrence of each is recorded.
  - If step = `NUM_STEPS`−1: go to RET_STEP with the macro, else FINISH. Otherwise increment the step index and go to STEP.
- **STEP.** Assert `ps_en_o` for one cycle with `ps_incdec_o`=1, then go to WAIT_DONE.
- **WAIT_DONE.** On `ps_done_i`, go to SETTLE. If 255 cycles pass without `ps_done_i`: set `err_o`, go to FINISH.
- **FINISH.** Pulse `done_o`, clear `busy_o`, return to IDLE.

Edge cases:
- `ps_done_i` outside WAIT_DONE/RET_WAIT is ignored.
- A reset mid-scan returns to IDLE immediately. The MMCM phase is not restored; software resets the MMCM.

## Timing
- Reset values: every output 0; step index 0; state IDLE.
- All outputs are registered.
- `busy_o` rises the cycle after an accepted `start_i` and falls in the same cycle `done_o` pulses.
- `ps_incdec_o` is stable from the `ps_en_o` cycle through `ps_done_i`. `ps_en_o` is never high for two consecutive cycles.
- Per-step latency: 1 (STEP) + PSDONE latency + `SETTLE` + 2^`LOG2_SAMPLES` + 1 (REPORT).
- `step_idx_o` and `step_count_o` hold until the next strobe. The edge outputs hold until the next start.
- The selection mux is registered (1 cycle). `SETTLE` covers the `CLK_PS` register, 2 synchronizer flops and the mux.

## Configuration
Macro `RITC_PHASE_SCAN_RETURN_EN`:
- **Defined:** after the last REPORT, issue `NUM_STEPS`−1 decrement shifts (`ps_incdec_o`=0), one per RET_STEP/RET_WAIT pair, then FINISH. The phase ends at its starting position. The same 255-cycle timeout applies.
- **Undefined:** go from the last REPORT directly to FINISH, leaving the phase advanced by `NUM_STEPS`−1 steps.

## Structure
- Package `ritc_phase_scan_pkg` holds:
  - the state enum;
  - select constants `SEL_CLK_BASE`=0, `SEL_DATA_BASE`=3, `SEL_VCDL`=39, `SEL_MAX`=39;
  - `PS_TIMEOUT`=255.
- Sub-module `ritc_phase_scan_mux`: registered 40:1 bit select from the latched `sel_i`.

## Test plan
- `NUM_STEPS`=8, MMCM model with PSDONE 3 cycles after PSEN, `sel_i`=0, `clk_q_i[0]` = 0 for steps 0–2 and 1 for steps 3–7 → counts 0,0,0,16,16,16,16,16; `rise_step_o`=3; `fall_found_o`=0; exactly 7 PSEN pulses.
- Level 1,1,0,0,1,… on `sel_i`=39 → `fall_step_o`=2, `rise_step_o`=4. Step count exactly 8 → level 0.
- `sel_i`=45 → `err_o`=1 and `done_o` within 3 cycles, no PSEN.
- PSDONE withheld → `err_o`=1 and `done_o` after 255 cycles in WAIT_DONE.
- With `RITC_PHASE_SCAN_RETURN_EN`, `NUM_STEPS`=8 → 7 increment and 7 decrement PSEN pulses; model phase back to 0. `start_i` while busy is ignored.
- Reset asserted mid-SAMPLE → all outputs 0 immediately; a new start runs a normal scan.
